// File: rtl/dotn_pkg.sv
// Shared types and elaboration helpers for the dotn_acc dot-product engine.
package dotn_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Width of adder-tree level `level`; level 0 holds the raw lane products.
  function automatic int tree_width(input int data_width, input int level);
    return 2 * data_width + level;
  endfunction

  // Multiplier stage + one register per tree level + accumulator/output stage.
  function automatic int total_latency(input int n_lanes);
    return 2 + clog2(n_lanes);
  endfunction

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } sideband_t;

endpackage

// File: rtl/dotn_acc_if.sv
// Operand-beat and result bus of dotn_acc; feeder side is master, engine is slave.
interface dotn_acc_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N_LANES    = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                          in_valid;
  logic                          in_first;
  logic                          in_last;
  logic [N_LANES*DATA_WIDTH-1:0] a_in;
  logic [N_LANES*DATA_WIDTH-1:0] b_in;
  logic signed [ACC_WIDTH-1:0]   res_out;
  logic                          res_valid;
  logic [CNT_WIDTH-1:0]          res_count;
  logic                          ovf_out;

  modport master (
    output in_valid, in_first, in_last, a_in, b_in,
    input  res_out, res_valid, res_count, ovf_out
  );

  modport slave (
    input  in_valid, in_first, in_last, a_in, b_in,
    output res_out, res_valid, res_count, ovf_out
  );
endinterface

// File: rtl/dotn_adder_tree.sv
// Pipelined signed reduction tree: lanes summed pairwise, one register per level,
// sideband delayed alongside so it stays aligned with the partial sums.
module dotn_adder_tree
  import dotn_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int N_LANES    = 16,
  localparam int LEVELS     = clog2(N_LANES),
  localparam int LEAF_W     = tree_width(DATA_WIDTH, 0),
  localparam int SUM_W      = tree_width(DATA_WIDTH, LEVELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [N_LANES*LEAF_W-1:0] leaves,
  input  sideband_t                 sb_in,
  output logic signed [SUM_W-1:0]   sum,
  output sideband_t                 sb_out
);

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int W     = tree_width(DATA_WIDTH, l);
    localparam int NODES = N_LANES >> l;
    logic signed [W-1:0] node [NODES];
    sideband_t           sb;

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < NODES; i++) begin : g_node
        assign node[i] = leaves[i*LEAF_W +: LEAF_W];
      end
      assign sb = sb_in;
    end else begin : g_add
      // Each operand is sign-extended by one bit so the pairwise add cannot wrap.
      always_ff @(posedge clk) begin
        if (rst) begin
          sb <= '0;
          for (int i = 0; i < NODES; i++) node[i] <= '0;
        end else if (ena) begin
          sb <= g_lvl[l-1].sb;
          for (int i = 0; i < NODES; i++)
            node[i] <= {g_lvl[l-1].node[2*i][W-2], g_lvl[l-1].node[2*i]}
                     + {g_lvl[l-1].node[2*i+1][W-2], g_lvl[l-1].node[2*i+1]};
        end
      end
    end
  end

  assign sum    = g_lvl[LEVELS].node[0];
  assign sb_out = g_lvl[LEVELS].sb;

endmodule

// File: rtl/dotn_acc.sv
// Signed N-lane dot-product engine: product stage, pipelined adder tree and a
// framed multi-beat accumulator with beat count and sticky overflow per result.
module dotn_acc
  import dotn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N_LANES    = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  dotn_acc_if.slave  bus
);

  localparam int PROD_W = tree_width(DATA_WIDTH, 0);
  localparam int LEVELS = clog2(N_LANES);
  localparam int SUM_W  = tree_width(DATA_WIDTH, LEVELS);

  if (N_LANES < 2 || (1 << LEVELS) != N_LANES) begin : g_chk_lanes
    $error("dotn_acc: N_LANES must be a power of two and at least 2");
  end
  if (ACC_WIDTH < SUM_W) begin : g_chk_acc
    $error("dotn_acc: ACC_WIDTH must be at least 2*DATA_WIDTH+log2(N_LANES)");
  end

  function automatic logic signed [PROD_W-1:0] lane_mul(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [PROD_W-1:0] a_x;
    logic signed [PROD_W-1:0] b_x;
    a_x = a;
    b_x = b;
    return a_x * b_x;
  endfunction

  logic [N_LANES*PROD_W-1:0] prod_d;
  logic [N_LANES*PROD_W-1:0] prod_q;
  sideband_t                 sb_d;
  sideband_t                 sb_m;
  sideband_t                 sb_a;
  logic signed [SUM_W-1:0]   tree_sum;

  always_comb begin
    prod_d = '0;
    for (int i = 0; i < N_LANES; i++)
      prod_d[i*PROD_W +: PROD_W] = lane_mul(bus.a_in[i*DATA_WIDTH +: DATA_WIDTH],
                                            bus.b_in[i*DATA_WIDTH +: DATA_WIDTH]);
  end

  assign sb_d = sideband_t'{valid: bus.in_valid, first: bus.in_first, last: bus.in_last};

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      sb_m   <= '0;
    end else if (ena) begin
      prod_q <= prod_d;
      sb_m   <= sb_d;
    end
  end

  dotn_adder_tree #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_LANES    (N_LANES)
  ) u_tree (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .leaves (prod_q),
    .sb_in  (sb_m),
    .sum    (tree_sum),
    .sb_out (sb_a)
  );

  logic signed [ACC_WIDTH-1:0] sum_ext;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic [CNT_WIDTH-1:0]        cnt_q;
  logic [CNT_WIDTH-1:0]        cnt_d;
  logic                        ovf_q;
  logic                        ovf_d;
  logic                        add_ovf;
  logic                        fresh_q;
  logic                        start;
  logic signed [ACC_WIDTH-1:0] res_q;
  logic [CNT_WIDTH-1:0]        res_cnt_q;
  logic                        res_ovf_q;
  logic                        res_pulse_q;

  assign sum_ext = ACC_WIDTH'(tree_sum);
  assign acc_sum = acc_q + sum_ext;
  // Two's-complement overflow: operands agree in sign but the result does not.
  assign add_ovf = (acc_q[ACC_WIDTH-1] == sum_ext[ACC_WIDTH-1])
                && (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
  // fresh_q marks "no open frame": after reset or after a closing beat.
  assign start   = sb_a.first | fresh_q;

  always_comb begin
    acc_d = acc_sum;
    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    ovf_d = ovf_q | add_ovf;
    if (start) begin
      acc_d = sum_ext;
      cnt_d = CNT_WIDTH'(1);
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      fresh_q     <= 1'b1;
      res_q       <= '0;
      res_cnt_q   <= '0;
      res_ovf_q   <= 1'b0;
      res_pulse_q <= 1'b0;
    end else if (ena) begin
      res_pulse_q <= 1'b0;
      if (sb_a.valid) begin
        acc_q   <= acc_d;
        cnt_q   <= cnt_d;
        ovf_q   <= ovf_d;
        fresh_q <= sb_a.last;
        if (sb_a.last) begin
          res_q       <= acc_d;
          res_cnt_q   <= cnt_d;
          res_ovf_q   <= ovf_d;
          res_pulse_q <= 1'b1;
        end
      end
    end
  end

  // The pulse register holds through a stall, so gate it to keep res_valid low
  // while ena=0; it is seen in exactly one ena-high cycle.
  assign bus.res_valid = res_pulse_q & ena;
  assign bus.res_out   = res_q;
  assign bus.res_count = res_cnt_q;
  assign bus.ovf_out   = res_ovf_q;

endmodule

// File: tb/tb_dotn_acc.sv
// Self-checking bench for dotn_acc: a wide (32-bit acc) and a narrow (20-bit acc,
// 3-bit count) instance share stimulus and are compared against a frame-level model.
module tb_dotn_acc;

  localparam int DW  = 8;
  localparam int NL  = 16;
  localparam int LAT = 6;
  localparam int W0  = 32;
  localparam int C0  = 16;
  localparam int W1  = 20;
  localparam int C1  = 3;

  typedef logic [NL*DW-1:0] vec_t;

  typedef struct {
    longint res0;
    longint res1;
    longint cnt0;
    longint cnt1;
    bit     ovf0;
    bit     ovf1;
    longint due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic ena;

  always #5 clk = ~clk;

  dotn_acc_if #(.DATA_WIDTH(DW), .N_LANES(NL), .ACC_WIDTH(W0), .CNT_WIDTH(C0)) bus0 ();
  dotn_acc_if #(.DATA_WIDTH(DW), .N_LANES(NL), .ACC_WIDTH(W1), .CNT_WIDTH(C1)) bus1 ();

  dotn_acc #(.DATA_WIDTH(DW), .N_LANES(NL), .ACC_WIDTH(W0), .CNT_WIDTH(C0)) dut0 (
    .clk (clk), .rst (rst), .ena (ena), .bus (bus0)
  );
  dotn_acc #(.DATA_WIDTH(DW), .N_LANES(NL), .ACC_WIDTH(W1), .CNT_WIDTH(C1)) dut1 (
    .clk (clk), .rst (rst), .ena (ena), .bus (bus1)
  );

  int     checks = 0;
  int     errors = 0;
  int     pulses = 0;
  bit     do_check = 0;
  exp_t   pend[$];
  exp_t   shown;
  longint ecount = 0;
  longint macc0, macc1, mcnt;
  bit     movf0, movf1;
  bit     mfresh = 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic longint wrap(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic bit fits(input longint v, input int w);
    return (v >= -(longint'(1) << (w - 1))) && (v < (longint'(1) << (w - 1)));
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint top;
    top = (longint'(1) << w) - 1;
    return (v > top) ? top : v;
  endfunction

  function automatic vec_t fill(input int val);
    vec_t v;
    for (int i = 0; i < NL; i++) v[i*DW +: DW] = DW'(val);
    return v;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int i = 0; i < NL*DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Frame rules applied directly on whole integers, one accepted beat at a time.
  task automatic accept(input bit f, input bit l, input vec_t a, input vec_t b);
    longint dot, t;
    logic signed [DW-1:0] ai, bi;
    exp_t e;
    dot = 0;
    for (int i = 0; i < NL; i++) begin
      ai = a[i*DW +: DW];
      bi = b[i*DW +: DW];
      dot += longint'(ai) * longint'(bi);
    end
    if (f || mfresh) begin
      macc0 = wrap(dot, W0);
      macc1 = wrap(dot, W1);
      mcnt  = 1;
      movf0 = 0;
      movf1 = 0;
    end else begin
      t = macc0 + dot;
      movf0 |= !fits(t, W0);
      macc0 = wrap(t, W0);
      t = macc1 + dot;
      movf1 |= !fits(t, W1);
      macc1 = wrap(t, W1);
      mcnt++;
    end
    mfresh = l;
    if (l) begin
      e.res0 = macc0;
      e.res1 = macc1;
      e.cnt0 = sat(mcnt, C0);
      e.cnt1 = sat(mcnt, C1);
      e.ovf0 = movf0;
      e.ovf1 = movf1;
      e.due  = ecount + LAT - 1;
      pend.push_back(e);
    end
  endtask

  task automatic model_edge(input bit v, input bit f, input bit l, input vec_t a, input vec_t b);
    if (rst) begin
      pend.delete();
      shown  = '{default: 0};
      mfresh = 1;
    end else if (ena) begin
      if (pend.size() > 0 && pend[0].due == ecount) void'(pend.pop_front());
      ecount++;
      if (v) accept(f, l, a, b);
      if (pend.size() > 0 && pend[0].due == ecount) shown = pend[0];
    end
  endtask

  task automatic check_cycle();
    bit ev;
    ev = ena && pend.size() > 0 && pend[0].due == ecount;
    if (bus0.res_valid === 1'b1) pulses++;
    chk("valid0", bus0.res_valid, ev);
    chk("valid1", bus1.res_valid, ev);
    chk("res0",   bus0.res_out,   shown.res0);
    chk("res1",   bus1.res_out,   shown.res1);
    chk("cnt0",   bus0.res_count, shown.cnt0);
    chk("cnt1",   bus1.res_count, shown.cnt1);
    chk("ovf0",   bus0.ovf_out,   shown.ovf0);
    chk("ovf1",   bus1.ovf_out,   shown.ovf1);
  endtask

  task automatic tick(input bit e, input bit v, input bit f, input bit l, input vec_t a, input vec_t b);
    ena = e;
    bus0.in_valid = v; bus0.in_first = f; bus0.in_last = l; bus0.a_in = a; bus0.b_in = b;
    bus1.in_valid = v; bus1.in_first = f; bus1.in_last = l; bus1.a_in = a; bus1.b_in = b;
    #2;
    if (do_check) check_cycle();
    @(posedge clk);
    model_edge(v, f, l, a, b);
    #1;
  endtask

  task automatic beat(input bit f, input bit l, input int a, input int b);
    tick(1, 1, f, l, fill(a), fill(b));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, $urandom_range(0, 1), $urandom_range(0, 1), rnd_vec(), rnd_vec());
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) tick(0, 1, 1, 1, rnd_vec(), rnd_vec());
  endtask

  initial begin
    shown = '{default: 0};
    rst = 1;
    tick(1, 0, 0, 0, '0, '0);
    tick(1, 0, 0, 0, '0, '0);
    rst = 0;
    do_check = 1;
    chk("rst_res", bus0.res_out, 0);
    chk("rst_valid", bus0.res_valid, 0);

    // single beat, lanes 1*1
    pulses = 0;
    beat(1, 1, 1, 1);
    idle(10);
    chk("t1_res", bus0.res_out, 16);
    chk("t1_cnt", bus0.res_count, 1);
    chk("t1_pulses", pulses, 1);

    // four-beat frame of -128*-128
    beat(1, 0, -128, -128);
    beat(0, 0, -128, -128);
    beat(0, 0, -128, -128);
    beat(0, 1, -128, -128);
    idle(8);
    chk("t2_res", bus0.res_out, 1048576);
    chk("t2_cnt", bus0.res_count, 4);
    chk("t2_ovf", bus0.ovf_out, 0);

    // stall right after the beat
    beat(1, 1, 1, 1);
    stall(3);
    idle(10);
    chk("t3_res", bus0.res_out, 16);

    // overflow in the 20-bit instance, then a clean single beat
    beat(1, 0, -128, -128);
    beat(0, 1, -128, -128);
    idle(8);
    chk("t4_res_narrow", bus1.res_out, -524288);
    chk("t4_ovf_narrow", bus1.ovf_out, 1);
    chk("t4_res_wide", bus0.res_out, 524288);
    beat(1, 1, 1, 1);
    idle(8);
    chk("t4b_res_narrow", bus1.res_out, 16);
    chk("t4b_ovf_narrow", bus1.ovf_out, 0);

    // back-to-back framing with bubbles
    beat(1, 1, 1, 2);
    idle(1);
    beat(0, 0, 1, 3);
    idle(2);
    beat(0, 1, 1, 1);
    idle(10);
    chk("t5_res", bus0.res_out, 64);
    chk("t5_cnt", bus0.res_count, 2);

    // reset with non-last beats in flight
    beat(1, 0, 1, 1);
    beat(0, 0, 1, 1);
    beat(0, 0, 1, 1);
    rst = 1;
    tick(1, 0, 0, 0, '0, '0);
    rst = 0;
    pulses = 0;
    beat(0, 1, 1, 1);
    idle(10);
    chk("t6_res", bus0.res_out, 16);
    chk("t6_cnt", bus0.res_count, 1);
    chk("t6_pulses", pulses, 1);

    // first in mid-frame discards the partial sum
    beat(1, 0, 5, 5);
    beat(0, 0, 5, 5);
    beat(1, 0, 1, 1);
    beat(0, 1, 1, 2);
    idle(8);
    chk("t7_res", bus0.res_out, 48);
    chk("t7_cnt", bus0.res_count, 2);

    // ten-beat frame saturates the 3-bit counter
    beat(1, 0, 1, 1);
    for (int i = 0; i < 8; i++) beat(0, 0, 1, 1);
    beat(0, 1, 1, 1);
    idle(8);
    chk("t8_cnt_wide", bus0.res_count, 10);
    chk("t8_cnt_narrow", bus1.res_count, 7);
    chk("t8_res", bus0.res_out, 160);

    // random traffic with random stalls
    for (int i = 0; i < 400; i++)
      tick(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 5) == 0,
           ($urandom % 4) == 0, rnd_vec(), rnd_vec());
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
